board_memory_wb: RTL and testbench



---
 rtl/board_pkg.sv | 28 ++
 rtl/board_sweep_ctrl.sv | 72 +++++++
 rtl/board_memory_wb.sv | 93 +++++++++
 tb/tb_board_memory_wb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared types and constants for the minefield board store.
package board_pkg;

  // One board cell, MSB first.
  typedef struct packed {
    logic       mine;
    logic       flag;
    logic       defused;
    logic [3:0] mine_ind;
    logic       spare;
  } field_t;

  localparam int DEF_ROWS = 16;
  localparam int DEF_COLS = 16;

  // SEL_I masks that touch exactly one field of field_t.
  localparam logic [7:0] MINE_MASK     = 8'h80;
  localparam logic [7:0] FLAG_MASK     = 8'h40;
  localparam logic [7:0] DEFUSED_MASK  = 8'h20;
  localparam logic [7:0] MINE_IND_MASK = 8'h1E;
  localparam logic [7:0] SPARE_MASK    = 8'h01;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/board_sweep_ctrl.sv
// Board clear sequencer: walks every cell once, row-major, col fastest.
module board_sweep_ctrl
  import board_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int ROW_W = $clog2(ROWS),
  parameter int COL_W = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  output logic             idle_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = $clog2(CELLS);

  sweep_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_d;
  logic             last;

  assign last   = (idx_q == IDX_W'(CELLS - 1));
  assign idle_o = (state_q == ST_IDLE);
  assign busy_o = (state_q == ST_SWEEP);
  // Constant divisor, so this folds to plain wiring when COLS is a power of two.
  assign row_o  = ROW_W'(idx_q / IDX_W'(COLS));
  assign col_o  = COL_W'(idx_q % IDX_W'(COLS));

  // State, index and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_o  <= done_d;
    end
  end

  // Next state: clear_i only matters in IDLE, so a sweep is never restarted.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (last) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/board_memory_wb.sv
// Wishbone-slave minefield store with masked writes, range check,
// hardware sweep and a separate registered display read port.
module board_memory_wb
  import board_pkg::*;
#(
  parameter int         ROWS      = DEF_ROWS,
  parameter int         COLS      = DEF_COLS,
  parameter int         ROW_W     = $clog2(ROWS),
  parameter int         COL_W     = $clog2(COLS),
  parameter logic [7:0] CLEAR_VAL = 8'h00
) (
  input  logic                   CLK_I,
  input  logic                   RST_NI,
  input  logic [ROW_W+COL_W-1:0] ADR_I,
  input  logic [7:0]             DAT_I,
  input  logic [7:0]             SEL_I,
  input  logic                   WE_I,
  input  logic                   CYC_I,
  input  logic                   STB_I,
  output logic [7:0]             DAT_O,
  output logic                   ACK_O,
  output logic                   ERR_O,
  input  logic                   clear_i,
  output logic                   busy_o,
  output logic                   done_o,
  input  logic [ROW_W-1:0]       disp_row_i,
  input  logic [COL_W-1:0]       disp_col_i,
  output logic [7:0]             disp_data_o
);

  logic [7:0]       mem [ROWS][COLS];

  logic [ROW_W-1:0] wb_row, sw_row;
  logic [COL_W-1:0] wb_col, sw_col;
  logic             wb_ok, disp_ok, idle, accept;

  assign wb_row  = ADR_I[ROW_W+COL_W-1:COL_W];
  assign wb_col  = ADR_I[COL_W-1:0];
  assign wb_ok   = (int'(wb_row) < ROWS) && (int'(wb_col) < COLS);
  assign disp_ok = (int'(disp_row_i) < ROWS) && (int'(disp_col_i) < COLS);

  // A clear request in the same cycle takes priority; the bus request just waits.
  assign accept  = CYC_I & STB_I & ~ACK_O & ~ERR_O & idle & ~clear_i;

  board_sweep_ctrl #(
    .ROWS (ROWS),
    .COLS (COLS),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_sweep (
    .clk    (CLK_I),
    .rst_n  (RST_NI),
    .clear_i(clear_i),
    .idle_o (idle),
    .busy_o (busy_o),
    .done_o (done_o),
    .row_o  (sw_row),
    .col_o  (sw_col)
  );

  // Cell array: sweep and bus writes never coincide since the bus only
  // gets in while the sweeper is idle. No reset, so an aborted sweep
  // leaves whatever it already cleared.
  always_ff @(posedge CLK_I) begin
    if (busy_o)
      mem[sw_row][sw_col] <= CLEAR_VAL;
    else if (accept && wb_ok && WE_I)
      mem[wb_row][wb_col] <= (mem[wb_row][wb_col] & ~SEL_I) | (DAT_I & SEL_I);
  end

  // Bus termination and read data; out-of-range leaves DAT_O untouched.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
      DAT_O <= 8'h00;
    end else begin
      ACK_O <= accept & wb_ok;
      ERR_O <= accept & ~wb_ok;
      if (accept && wb_ok && !WE_I)
        DAT_O <= mem[wb_row][wb_col];
    end
  end

  // Display port: plain registered read, sees pre-write data on a collision.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI)
      disp_data_o <= 8'h00;
    else
      disp_data_o <= disp_ok ? mem[disp_row_i][disp_col_i] : 8'h00;
  end

endmodule

// File: tb/tb_board_memory_wb.sv
// Scoreboard bench: two instances (16x16 and 10x12) share one bus,
// selected by separate CYC lines.
module tb_board_memory_wb;
  import board_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] adr = '0, dat = '0, sel = '0;
  logic       we = 1'b0, stb = 1'b0, cyc_a = 1'b0, cyc_b = 1'b0;
  logic       clear_a = 1'b0, clear_b = 1'b0;
  logic [3:0] drow_a = '0, dcol_a = '0, drow_b = '0, dcol_b = '0;
  logic [7:0] dato_a, dato_b, disp_a, disp_b;
  logic       ack_a, err_a, busy_a, done_a, ack_b, err_b, busy_b, done_b;

  int nchk = 0, nfail = 0;
  int cyc_n = 0, done_cyc_a = -100, term_cyc = 0;

  typedef struct {
    bit         dut;
    bit         err;
    bit         chk_dat;
    logic [7:0] dat;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  board_memory_wb #(.ROWS(16), .COLS(16)) u_a (
    .CLK_I(clk), .RST_NI(rst_n), .ADR_I(adr), .DAT_I(dat), .SEL_I(sel),
    .WE_I(we), .CYC_I(cyc_a), .STB_I(stb), .DAT_O(dato_a), .ACK_O(ack_a),
    .ERR_O(err_a), .clear_i(clear_a), .busy_o(busy_a), .done_o(done_a),
    .disp_row_i(drow_a), .disp_col_i(dcol_a), .disp_data_o(disp_a)
  );

  board_memory_wb #(.ROWS(10), .COLS(12)) u_b (
    .CLK_I(clk), .RST_NI(rst_n), .ADR_I(adr), .DAT_I(dat), .SEL_I(sel),
    .WE_I(we), .CYC_I(cyc_b), .STB_I(stb), .DAT_O(dato_b), .ACK_O(ack_b),
    .ERR_O(err_b), .clear_i(clear_b), .busy_o(busy_b), .done_o(done_b),
    .disp_row_i(drow_b), .disp_col_i(dcol_b), .disp_data_o(disp_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic pop_chk(input bit dut, input logic ack, input logic err, input logic [7:0] d);
    exp_t e;
    if (q.size() == 0 || q[0].dut != dut) begin
      nchk++;
      nfail++;
      $display("FAIL unexpected_term: dut %0d ack %0b err %0b with nothing pending", dut, ack, err);
    end else begin
      e = q.pop_front();
      chk(dut ? "term_b" : "term_a", {ack, err}, e.err ? 2'b01 : 2'b10);
      if (e.chk_dat) chk(dut ? "dat_o_b" : "dat_o_a", d, e.dat);
    end
  endtask

  // Monitor: every termination the DUTs present must match the oldest expectation.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (done_a) done_cyc_a = cyc_n;
      if (ack_a || err_a) pop_chk(1'b0, ack_a, err_a, dato_a);
      if (ack_b || err_b) pop_chk(1'b1, ack_b, err_b, dato_b);
    end
  end

  // One bus transfer; the expectation goes to the scoreboard, lat counts cycles to termination.
  task automatic wb(input bit dut, input bit w, input logic [7:0] a, input logic [7:0] d,
                    input logic [7:0] s, input bit e_err, input bit e_chk, input logic [7:0] e_dat,
                    input bit clr, input int max_wait, output int lat);
    exp_t e;
    logic t;
    @(negedge clk);
    adr = a; dat = d; sel = s; we = w; stb = 1'b1;
    if (dut) cyc_b = 1'b1; else cyc_a = 1'b1;
    if (clr) begin
      if (dut) clear_b = 1'b1; else clear_a = 1'b1;
    end
    e = '{dut, e_err, e_chk, e_dat};
    q.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      clear_a = 1'b0;
      clear_b = 1'b0;
      t = dut ? (ack_b | err_b) : (ack_a | err_a);
    end while (!t && lat < max_wait);
    if (!t) begin
      nchk++;
      nfail++;
      $display("FAIL bus_timeout: no termination after %0d cycles, addr %0h", lat, a);
      void'(q.pop_back());
    end
    term_cyc = cyc_n;
    cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input bit dut, input logic [7:0] a, input logic [7:0] d, input logic [7:0] s);
    int lat;
    wb(dut, 1'b1, a, d, s, 1'b0, 1'b0, 8'h00, 1'b0, 8, lat);
    chk("wr_latency", lat, 1);
  endtask

  task automatic rd(input bit dut, input logic [7:0] a, input logic [7:0] exp);
    int lat;
    wb(dut, 1'b0, a, 8'h00, 8'h00, 1'b0, 1'b1, exp, 1'b0, 8, lat);
    chk("rd_latency", lat, 1);
  endtask

  task automatic bad(input bit dut, input bit w, input logic [7:0] a, input logic [7:0] prev);
    int lat;
    wb(dut, w, a, 8'hEE, 8'hFF, 1'b1, 1'b1, prev, 1'b0, 8, lat);
    chk("err_latency", lat, 1);
  endtask

  // Sweep with busy/done shape checks; retrig pulses clear_i mid-sweep (must be ignored).
  task automatic sweep(input bit dut, input int n, input int retrig);
    int busy_n = 0, done_n = 0, last_busy = -1, done_at = -1, first = 0;
    @(negedge clk);
    if (dut) clear_b = 1'b1; else clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0; clear_b = 1'b0;
    first = dut ? busy_b : busy_a;
    for (int k = 0; k < n + 20; k++) begin
      if (dut ? busy_b : busy_a) begin busy_n++; last_busy = k; end
      if (dut ? done_b : done_a) begin done_n++; done_at = k; end
      if (dut) clear_b = (k == retrig); else clear_a = (k == retrig);
      @(negedge clk);
    end
    clear_a = 1'b0; clear_b = 1'b0;
    chk("busy_rise", first, 1);
    chk("busy_cycles", busy_n, n);
    chk("busy_last", last_busy, n - 1);
    chk("done_pulses", done_n, 1);
    chk("done_after_busy", done_at, n);
  endtask

  initial begin
    #500000;
    nchk++;
    nfail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("rst_dat_o", {dato_a, dato_b}, 16'h0000);
    chk("rst_ack_err", {ack_a, err_a, ack_b, err_b}, 4'b0000);
    chk("rst_busy_done", {busy_a, done_a, busy_b, done_b}, 4'b0000);
    chk("rst_disp", {disp_a, disp_b}, 16'h0000);
    rst_n = 1'b1;

    // Full sweeps, A with an ignored retrigger at cycle 50.
    sweep(1'b0, 256, 50);
    sweep(1'b1, 120, -1);
    for (int i = 0; i < 256; i++) rd(1'b0, 8'(i), 8'h00);
    rd(1'b1, 8'h00, 8'h00);
    rd(1'b1, 8'h9B, 8'h00);

    // Masked writes.
    wr(1'b0, 8'h3C, 8'hA5, 8'hFF);
    wr(1'b0, 8'h3C, 8'h40, FLAG_MASK);
    rd(1'b0, 8'h3C, 8'hE5);
    wr(1'b0, 8'h3C, 8'hFF, 8'h00);
    rd(1'b0, 8'h3C, 8'hE5);
    wr(1'b0, 8'h3C, 8'h00, FLAG_MASK);
    rd(1'b0, 8'h3C, 8'hA5);
    wr(1'b0, 8'h3C, 8'h0A, MINE_IND_MASK);
    rd(1'b0, 8'h3C, 8'hAB);

    // Range check on the 10x12 instance.
    wr(1'b1, 8'h3B, 8'h5A, 8'hFF);
    wr(1'b1, 8'h40, 8'h11, 8'hFF);
    rd(1'b1, 8'h3B, 8'h5A);
    bad(1'b1, 1'b0, 8'hA0, 8'h5A);
    bad(1'b1, 1'b1, 8'h3C, 8'h5A);
    bad(1'b1, 1'b0, 8'h9C, 8'h5A);
    rd(1'b1, 8'h40, 8'h11);
    rd(1'b1, 8'h3B, 8'h5A);

    // Display port on B: in range, then out-of-range row and col.
    @(negedge clk); drow_b = 4'd3; dcol_b = 4'd11;
    @(negedge clk); chk("disp_b_inrange", disp_b, 8'h5A);
    drow_b = 4'd10; dcol_b = 4'd0;
    @(negedge clk); chk("disp_b_row_oor", disp_b, 8'h00);
    drow_b = 4'd0; dcol_b = 4'd12;
    @(negedge clk); chk("disp_b_col_oor", disp_b, 8'h00);

    // Display/write collision on A at row 2, col 7.
    wr(1'b0, 8'h27, 8'h33, 8'hFF);
    drow_a = 4'd2; dcol_a = 4'd7;
    @(negedge clk); chk("disp_a_pre", disp_a, 8'h33);
    wb(1'b0, 1'b1, 8'h27, 8'h80, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 8, lat);
    chk("disp_a_collision_old", disp_a, 8'h33);
    @(negedge clk); chk("disp_a_collision_new", disp_a, 8'h80);

    // Write issued 5 cycles into a sweep waits for it and survives.
    wr(1'b0, 8'h54, 8'h99, 8'hFF);
    @(negedge clk); clear_a = 1'b1;
    @(negedge clk); clear_a = 1'b0;
    repeat (4) @(negedge clk);
    wb(1'b0, 1'b1, 8'h55, 8'h77, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 400, lat);
    chk("stall_term_after_done", term_cyc, done_cyc_a + 1);
    rd(1'b0, 8'h55, 8'h77);
    rd(1'b0, 8'h54, 8'h00);
    rd(1'b0, 8'h3C, 8'h00);

    // clear_i and a request in the same cycle: sweep first.
    wb(1'b0, 1'b1, 8'h56, 8'h66, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 400, lat);
    chk("same_cycle_term_after_done", term_cyc, done_cyc_a + 1);
    chk("same_cycle_lat", lat, 258);
    rd(1'b0, 8'h56, 8'h66);

    // Reset at sweep cycle 100.
    wr(1'b0, 8'h00, 8'h09, 8'hFF);
    wr(1'b0, 8'h63, 8'h5E, 8'hFF);
    wr(1'b0, 8'h64, 8'hC3, 8'hFF);
    rd(1'b0, 8'h64, 8'hC3);
    @(negedge clk); clear_a = 1'b1;
    @(negedge clk); clear_a = 1'b0;
    repeat (100) @(negedge clk);
    chk("busy_before_abort", busy_a, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_dat_o", dato_a, 8'h00);
    chk("abort_flags", {ack_a, err_a, busy_a, done_a}, 4'b0000);
    chk("abort_disp", disp_a, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    rd(1'b0, 8'h00, 8'h00);
    rd(1'b0, 8'h63, 8'h00);
    rd(1'b0, 8'h64, 8'hC3);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
